data_unit_param: RTL

DATA_UNIT_PARAM -- requirements
Module: data_unit_param

---
 rtl/proc_pkg.sv | 25 ++
 rtl/imm_gen.sv | 29 ++
 rtl/data_unit_param.sv | 71 +++++++
 3 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared opcode constants, immediate field positions and format decode
package proc_pkg;

    localparam logic [2:0] OP_JAL = 3'b100;

    localparam int OPC_HI = 2;
    localparam int OPC_LO = 0;
    localparam int JAL_HI = 12;
    localparam int JAL_LO = 3;
    localparam int JAL_W  = JAL_HI - JAL_LO + 1;
    localparam int IMM_HI = 12;
    localparam int IMM_LO = 7;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    typedef enum logic [1:0] {
        IMM_SHORT,
        IMM_BRANCH,
        IMM_JAL
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [2:0] opcode, input logic branch);
        return opcode == OP_JAL ? IMM_JAL : branch ? IMM_BRANCH : IMM_SHORT;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: decodes the raw instruction word into a sign-extended immediate
module imm_gen
    import proc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      instr,
    input  logic             branch,
    output logic [WIDTH-1:0] imm
);

    logic [JAL_W-1:0] jal_field;
    logic [IMM_W-1:0] short_field;
    imm_fmt_e         fmt;
    logic             unused_hi;

    assign jal_field   = instr[JAL_HI:JAL_LO];
    assign short_field = instr[IMM_HI:IMM_LO];
    assign fmt         = imm_fmt(instr[OPC_HI:OPC_LO], branch);
    assign unused_hi   = ^instr[15:JAL_HI+1];

    // select the extension that matches the decoded immediate format
    always_comb begin
        imm = fmt == IMM_JAL    ? {{(WIDTH-JAL_W){jal_field[JAL_W-1]}}, jal_field} :
              fmt == IMM_BRANCH ? {{(WIDTH-IMM_W-1){short_field[IMM_W-1]}}, short_field, 1'b0} :
                                  {{(WIDTH-IMM_W){short_field[IMM_W-1]}}, short_field};
    end

endmodule

// File: rtl/data_unit_param.sv
// data_unit_param: register file with registered A/B read ports, write-back mux and immediate register
module data_unit_param
    import proc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] input_reg_readA_address,
    input  logic [ADDR_W-1:0] input_reg_readB_address,
    input  logic              input_load_AB,
    input  logic              input_reg_write,
    input  logic [ADDR_W-1:0] input_reg_write_address,
    input  logic              memToReg,
    input  logic [WIDTH-1:0]  input_ALUOut,
    input  logic [WIDTH-1:0]  input_MDR,
    input  logic [15:0]       input_imm,
    input  logic              input_branch,
    output logic [WIDTH-1:0]  output_imm,
    output logic [WIDTH-1:0]  output_reg_A,
    output logic [WIDTH-1:0]  output_reg_B,
    output logic [WIDTH-1:0]  output_wb_data
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] imm_next;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             wr_en;

    imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr  (input_imm),
        .branch (input_branch),
        .imm    (imm_next)
    );

    assign output_wb_data = memToReg ? input_MDR : input_ALUOut;

    // write qualification and read data with same-cycle bypass; a hardwired
    // zero register is neither written nor bypassed, so it always reads 0
    always_comb begin
        wr_en = input_reg_write && !(ZERO_REG != 0 && input_reg_write_address == '0);
        rd_a  = (ZERO_REG != 0 && input_reg_readA_address == '0) ? '0 :
                (wr_en && input_reg_readA_address == input_reg_write_address) ? output_wb_data :
                regs[input_reg_readA_address];
        rd_b  = (ZERO_REG != 0 && input_reg_readB_address == '0) ? '0 :
                (wr_en && input_reg_readB_address == input_reg_write_address) ? output_wb_data :
                regs[input_reg_readB_address];
    end

    // register array, A/B capture and immediate pipeline; reset wins over any write or load
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            output_reg_A <= '0;
            output_reg_B <= '0;
            output_imm   <= '0;
        end else begin
            if (wr_en) regs[input_reg_write_address] <= output_wb_data;
            if (input_load_AB) begin
                output_reg_A <= rd_a;
                output_reg_B <= rd_b;
            end
            output_imm <= imm_next;
        end
    end

endmodule
